// File: rtl/neighbor_score.sv
// Scores graph neighbours by squared Euclidean distance to a loaded target vector.
// Pops the neighbour and position FIFOs and emits (id, score) over valid/ready.
module neighbor_score #(
    parameter int DIM     = 2,
    parameter int COORD_W = 16,
    parameter int SCORE_W = 2*COORD_W+2+$clog2(DIM)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [31:0]        tgt_data_in,
    input  logic               tgt_valid_in,
    input  logic               start_in,
    input  logic [31:0]        neigh_data_in,
    input  logic               neigh_valid_in,
    input  logic               neigh_end_in,
    output logic               neigh_deq_out,
    input  logic [31:0]        pos_data_in,
    input  logic               pos_valid_in,
    output logic               pos_deq_out,
    output logic [31:0]        id_out,
    output logic [SCORE_W-1:0] score_out,
    output logic               score_valid_out,
    input  logic               score_ready_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [15:0]        scored_count_out
);
    localparam int KW   = $clog2(DIM);
    localparam int SQ_W = 2*COORD_W+2;

    typedef enum logic [1:0] {IDLE, WAIT, ACCUM, EMIT} state_t;

    state_t                     state_q, state_d;
    logic [KW-1:0]              ld_ct_q, ld_ct_d;
    logic [KW-1:0]              k_q, k_d;
    logic signed [COORD_W-1:0]  tgt_q [DIM];
    logic                       tgt_we;
    logic [SCORE_W-1:0]         acc_q, acc_d;
    logic [SCORE_W-1:0]         score_q, score_d;
    logic [31:0]                id_q, id_d;
    logic [15:0]                cnt_q, cnt_d;
    logic signed [COORD_W:0]    diff;
    logic [SQ_W-1:0]            sq;
    logic                       unused_bits;

    // One extra bit keeps the difference of two extreme coordinates exact.
    function automatic logic signed [COORD_W:0] coord_diff(input logic [COORD_W-1:0] a,
                                                         input logic [COORD_W-1:0] b);
        return $signed({a[COORD_W-1], a}) - $signed({b[COORD_W-1], b});
    endfunction

    function automatic logic [SQ_W-1:0] square(input logic signed [COORD_W:0] d);
        logic signed [SQ_W-1:0] dx;
        dx = {{(COORD_W+1){d[COORD_W]}}, d};
        return $unsigned(dx * dx);
    endfunction

    assign unused_bits = ^{tgt_data_in[31:COORD_W], pos_data_in[31:COORD_W]};

    always_comb begin
        state_d       = state_q;
        ld_ct_d       = ld_ct_q;
        k_d           = k_q;
        acc_d         = acc_q;
        score_d       = score_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        tgt_we        = 1'b0;
        neigh_deq_out = 1'b0;
        pos_deq_out   = 1'b0;
        done_out      = 1'b0;
        diff          = coord_diff(pos_data_in[COORD_W-1:0], tgt_q[k_q]);
        sq            = square(diff);
        case (state_q)
            IDLE: begin
                if (tgt_valid_in) begin
                    tgt_we  = 1'b1;
                    ld_ct_d = (ld_ct_q == KW'(DIM-1)) ? '0 : ld_ct_q + 1'b1;
                end
                if (start_in) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (neigh_valid_in) begin
                    neigh_deq_out = rst_in;
                    id_d          = neigh_data_in;
                    acc_d         = '0;
                    k_d           = '0;
                    state_d       = ACCUM;
                end else if (neigh_end_in) begin
                    done_out = rst_in;
                    state_d  = IDLE;
                end
            end
            ACCUM: begin
                pos_deq_out = pos_valid_in & rst_in;
                if (pos_valid_in) begin
                    acc_d = acc_q + SCORE_W'(sq);
                    if (k_q == KW'(DIM-1)) begin
                        score_d = acc_q + SCORE_W'(sq);
                        state_d = EMIT;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (score_ready_in) begin
                    state_d = WAIT;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            ld_ct_q <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            score_q <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DIM; i++) tgt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ld_ct_q <= ld_ct_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            score_q <= score_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            if (tgt_we) tgt_q[ld_ct_q] <= tgt_data_in[COORD_W-1:0];
        end
    end

    assign id_out           = id_q;
    assign score_out        = score_q;
    assign score_valid_out  = (state_q == EMIT);
    assign busy_out         = (state_q != IDLE);
    assign scored_count_out = cnt_q;
endmodule

// File: tb/tb_neighbor_score.sv
// Directed bench for neighbor_score (DIM=2, COORD_W=16): hand-computed scores,
// handshake timing, stalls, backpressure, end-of-list and mid-run reset.
module tb_neighbor_score;
    localparam int SCORE_W = 35;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic [31:0]        tgt_data_in = '0;
    logic               tgt_valid_in = 1'b0;
    logic               start_in = 1'b0;
    logic [31:0]        neigh_data_in = '0;
    logic               neigh_valid_in = 1'b0;
    logic               neigh_end_in = 1'b0;
    logic               neigh_deq_out;
    logic [31:0]        pos_data_in = '0;
    logic               pos_valid_in = 1'b0;
    logic               pos_deq_out;
    logic [31:0]        id_out;
    logic [SCORE_W-1:0] score_out;
    logic               score_valid_out;
    logic               score_ready_in = 1'b0;
    logic               busy_out;
    logic               done_out;
    logic [15:0]        scored_count_out;

    int n_cmp = 0;
    int n_fail = 0;

    neighbor_score dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .tgt_data_in(tgt_data_in), .tgt_valid_in(tgt_valid_in), .start_in(start_in),
        .neigh_data_in(neigh_data_in), .neigh_valid_in(neigh_valid_in),
        .neigh_end_in(neigh_end_in), .neigh_deq_out(neigh_deq_out),
        .pos_data_in(pos_data_in), .pos_valid_in(pos_valid_in), .pos_deq_out(pos_deq_out),
        .id_out(id_out), .score_out(score_out), .score_valid_out(score_valid_out),
        .score_ready_in(score_ready_in), .busy_out(busy_out), .done_out(done_out),
        .scored_count_out(scored_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_id"}, 64'(id_out), 64'd0);
        chk({tag, "_score"}, 64'(score_out), 64'd0);
        chk({tag, "_valid"}, 64'(score_valid_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy_out), 64'd0);
        chk({tag, "_done"}, 64'(done_out), 64'd0);
        chk({tag, "_count"}, 64'(scored_count_out), 64'd0);
        chk({tag, "_ndeq"}, 64'(neigh_deq_out), 64'd0);
        chk({tag, "_pdeq"}, 64'(pos_deq_out), 64'd0);
    endtask

    // Entered with the DUT about to be in WAIT at the next edge; leaves it in EMIT
    // with score_ready_in high so the result is accepted at the following edge.
    task automatic score_one(input logic [31:0] id, input logic [31:0] p0, input logic [31:0] p1,
                             input logic [63:0] exp, input int hold, input int stall);
        step();
        start_in = 1'b0; score_ready_in = 1'b0; pos_valid_in = 1'b0;
        neigh_valid_in = 1'b1; neigh_data_in = id;
        @(negedge clk_in);
        chk("neigh_deq", 64'(neigh_deq_out), 64'd1);
        chk("pos_deq_in_wait", 64'(pos_deq_out), 64'd0);
        chk("busy_wait", 64'(busy_out), 64'd1);
        step();
        neigh_valid_in = 1'b0; pos_valid_in = 1'b1; pos_data_in = p0;
        @(negedge clk_in);
        chk("pos_deq_k0", 64'(pos_deq_out), 64'd1);
        chk("neigh_deq_accum", 64'(neigh_deq_out), 64'd0);
        chk("valid_early1", 64'(score_valid_out), 64'd0);
        for (int i = 0; i < stall; i++) begin
            step();
            pos_valid_in = 1'b0;
            @(negedge clk_in);
            chk("pos_deq_stall", 64'(pos_deq_out), 64'd0);
            chk("valid_stall", 64'(score_valid_out), 64'd0);
        end
        step();
        pos_valid_in = 1'b1; pos_data_in = p1;
        @(negedge clk_in);
        chk("pos_deq_k1", 64'(pos_deq_out), 64'd1);
        chk("valid_early2", 64'(score_valid_out), 64'd0);
        step();
        pos_valid_in = 1'b0;
        score_ready_in = (hold == 0);
        if (hold > 0) begin
            neigh_valid_in = 1'b1; neigh_data_in = 32'd9;
        end
        @(negedge clk_in);
        chk("score_valid", 64'(score_valid_out), 64'd1);
        chk("id", 64'(id_out), 64'(id));
        chk("score", 64'(score_out), exp);
        chk("neigh_deq_emit", 64'(neigh_deq_out), 64'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            score_ready_in = (i == hold - 1);
            @(negedge clk_in);
            chk("bp_valid", 64'(score_valid_out), 64'd1);
            chk("bp_id", 64'(id_out), 64'(id));
            chk("bp_score", 64'(score_out), exp);
            chk("bp_neigh_deq", 64'(neigh_deq_out), 64'd0);
        end
    endtask

    task automatic load_target(input logic [31:0] t0, input logic [31:0] t1);
        step();
        tgt_valid_in = 1'b1; tgt_data_in = t0;
        step();
        tgt_data_in = t1;
        step();
        tgt_valid_in = 1'b0; start_in = 1'b1;
    endtask

    task automatic finish_list(input logic [63:0] exp_cnt);
        step();
        score_ready_in = 1'b0; tgt_valid_in = 1'b0; neigh_end_in = 1'b1;
        @(negedge clk_in);
        chk("done_pulse", 64'(done_out), 64'd1);
        chk("busy_at_done", 64'(busy_out), 64'd1);
        chk("count_at_done", 64'(scored_count_out), exp_cnt);
        step();
        neigh_end_in = 1'b0;
        @(negedge clk_in);
        chk("done_cleared", 64'(done_out), 64'd0);
        chk("busy_after_done", 64'(busy_out), 64'd0);
        chk("count_held", 64'(scored_count_out), exp_cnt);
    endtask

    initial begin
        // Power-on reset
        step();
        @(negedge clk_in);
        chk_reset("por");
        step();
        rst_in = 1'b1;

        // Basic, negative coordinate (upper word bits ignored), backpressure, stall
        load_target(32'd3, 32'hDEAD_0004);
        score_one(32'd7, 32'd0, 32'd0, 64'd25, 0, 0);
        score_one(32'd11, 32'h0000_FFFE, 32'd4, 64'd25, 5, 0);
        score_one(32'd9, 32'd1, 32'd2, 64'd8, 0, 4);
        score_one(32'd12, 32'd1, 32'd2, 64'd8, 0, 0);
        finish_list(64'd4);

        // Extreme coordinate difference
        load_target(32'h0000_7FFF, 32'd0);
        score_one(32'd5, 32'h0000_8000, 32'd0, 64'd4294836225, 0, 0);
        finish_list(64'd1);

        // End handling with neigh_end_in held and target writes attempted while busy
        load_target(32'd3, 32'd4);
        step();
        start_in = 1'b0;
        @(negedge clk_in);
        chk("busy_after_start", 64'(busy_out), 64'd1);
        chk("count_cleared", 64'(scored_count_out), 64'd0);
        chk("no_done_idle_wait", 64'(done_out), 64'd0);
        score_one(32'd31, 32'd0, 32'd0, 64'd25, 0, 0);
        neigh_end_in = 1'b1; tgt_valid_in = 1'b1; tgt_data_in = 32'd100;
        score_one(32'd32, 32'd1, 32'd2, 64'd8, 0, 0);
        score_one(32'd33, 32'd3, 32'd4, 64'd0, 0, 0);
        finish_list(64'd3);
        step();
        start_in = 1'b1;
        score_one(32'd34, 32'd0, 32'd0, 64'd25, 0, 0);
        finish_list(64'd1);

        // Reset in the middle of accumulation
        step();
        start_in = 1'b1;
        step();
        start_in = 1'b0; neigh_valid_in = 1'b1; neigh_data_in = 32'd40;
        @(negedge clk_in);
        chk("rst_pre_ndeq", 64'(neigh_deq_out), 64'd1);
        step();
        neigh_valid_in = 1'b0; pos_valid_in = 1'b1; pos_data_in = 32'd5;
        step();
        pos_valid_in = 1'b0; rst_in = 1'b0;
        step();
        @(negedge clk_in);
        chk_reset("mid_rst");
        step();
        rst_in = 1'b1;
        tgt_valid_in = 1'b1; tgt_data_in = 32'd3;
        step();
        tgt_data_in = 32'd4;
        step();
        tgt_valid_in = 1'b0; start_in = 1'b1;
        score_one(32'd41, 32'd7, 32'd8, 64'd32, 0, 0);
        step();
        score_ready_in = 1'b0;
        @(negedge clk_in);
        chk("final_count", 64'(scored_count_out), 64'd1);
        chk("final_valid", 64'(score_valid_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
